// File: rtl/sseg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sseg_pkg
//  Purpose  : Shared constants, frame type and anode helper for the
//             seven-segment display path.
//  Revision : 1.0 - initial release
// ============================================================================
package sseg_pkg;

    localparam logic [6:0] SSEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF     = 4'hF;
    localparam int         NUM_DIGITS = 4;

    typedef struct packed {
        logic [NUM_DIGITS-1:0]      dp;
        logic [NUM_DIGITS-1:0][6:0] seg;
    } sseg_frame_t;

    localparam sseg_frame_t FRAME_BLANK = sseg_frame_t'({4'hF, {NUM_DIGITS{SSEG_BLANK}}});

    // Active-low one-cold anode pattern selecting a single digit.
    function automatic logic [3:0] anode_sel(input logic [1:0] digit);
        return ~(4'b0001 << digit);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sseg_pwm_gate.sv
`default_nettype none
// ============================================================================
//  Module   : sseg_pwm_gate
//  Purpose  : Free-running PWM counter and duty compare for display dimming.
//  Revision : 1.0 - initial release
// ============================================================================
module sseg_pwm_gate #(
    parameter int BRIGHT_W = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [BRIGHT_W-1:0] level_i,
    output logic                pwm_on_o
);

    logic [BRIGHT_W-1:0] r_pwm_cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
        end
    end

    // All-ones must be fully on, which a plain less-than compare cannot reach.
    assign pwm_on_o = (level_i == '1) || (r_pwm_cnt < level_i);

endmodule
`default_nettype wire

// File: rtl/sseg_frame_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : sseg_frame_scanner
//  Purpose  : Double-buffered 4-digit seven-segment scanner with blanking
//             between digits and PWM brightness, updated only per frame.
//  Revision : 1.0 - initial release
// ============================================================================
module sseg_frame_scanner
    import sseg_pkg::*;
#(
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int BRIGHT_W     = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [27:0]         frame_i,
    input  logic [3:0]          dp_i,
    input  logic                frame_valid_i,
    output logic                frame_ready_o,
    input  logic [BRIGHT_W-1:0] brightness_i,
    output logic [3:0]          an_o,
    output logic [6:0]          sseg_o,
    output logic                dp_o,
    output logic                frame_start_o
);

    localparam int                  c_SLOT_W    = $clog2(DIGIT_CYCLES);
    localparam logic [c_SLOT_W-1:0] c_SLOT_LAST = c_SLOT_W'(DIGIT_CYCLES - 1);
    localparam logic [c_SLOT_W-1:0] c_BLANK_END = c_SLOT_W'(BLANK_CYCLES);

    logic [c_SLOT_W-1:0] r_slot_cnt;
    logic [1:0]          r_digit;
    sseg_frame_t         r_active;
    sseg_frame_t         r_pending;
    logic                r_pending_full;
    logic [BRIGHT_W-1:0] r_bright;

    logic [3:0]          r_an;
    logic [6:0]          r_sseg;
    logic                r_dp;
    logic                r_frame_start;

    logic                w_boundary;
    logic                w_accept;
    logic                w_pwm_on;
    logic                w_lit;

    assign w_boundary = (r_slot_cnt == '0) && (r_digit == 2'd0);
    assign w_accept   = frame_valid_i && !r_pending_full;
    assign w_lit      = (r_slot_cnt >= c_BLANK_END) && w_pwm_on;

    sseg_pwm_gate #(
        .BRIGHT_W (BRIGHT_W)
    ) u_pwm_gate (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .level_i  (r_bright),
        .pwm_on_o (w_pwm_on)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_slot_cnt <= '0;
            r_digit    <= 2'd0;
        end else if (r_slot_cnt == c_SLOT_LAST) begin
            r_slot_cnt <= '0;
            r_digit    <= r_digit + 2'd1;
        end else begin
            r_slot_cnt <= r_slot_cnt + 1'b1;
        end
    end

    // A boundary with a full pending buffer keeps ready low, so it can never
    // coincide with an accept; an accept on an empty boundary stays pending.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_active       <= FRAME_BLANK;
            r_pending      <= FRAME_BLANK;
            r_pending_full <= 1'b0;
            r_bright       <= '0;
        end else begin
            if (w_boundary) begin
                r_bright <= brightness_i;
            end
            if (w_boundary && r_pending_full) begin
                r_active       <= r_pending;
                r_pending_full <= 1'b0;
            end else if (w_accept) begin
                r_pending      <= sseg_frame_t'({dp_i, frame_i});
                r_pending_full <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_an          <= AN_OFF;
            r_sseg        <= SSEG_BLANK;
            r_dp          <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_boundary;
            if (w_lit) begin
                r_an   <= anode_sel(r_digit);
                r_sseg <= r_active.seg[r_digit];
                r_dp   <= r_active.dp[r_digit];
            end else begin
                r_an   <= AN_OFF;
                r_sseg <= SSEG_BLANK;
                r_dp   <= 1'b1;
            end
        end
    end

    assign frame_ready_o = !r_pending_full;
    assign an_o          = r_an;
    assign sseg_o        = r_sseg;
    assign dp_o          = r_dp;
    assign frame_start_o = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_sseg_frame_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sseg_frame_scanner
//  Purpose  : Self-checking bench for sseg_frame_scanner against a
//             time-indexed reference model of the display schedule.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sseg_frame_scanner;

    localparam int DC = 8;
    localparam int BC = 2;
    localparam int BW = 2;

    logic          clk;
    logic          rst_i;
    logic [27:0]   frame_i;
    logic [3:0]    dp_i;
    logic          frame_valid_i;
    logic          frame_ready_o;
    logic [BW-1:0] brightness_i;
    logic [3:0]    an_o;
    logic [6:0]    sseg_o;
    logic          dp_o;
    logic          frame_start_o;

    sseg_frame_scanner #(
        .DIGIT_CYCLES (DC),
        .BLANK_CYCLES (BC),
        .BRIGHT_W     (BW)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .frame_i       (frame_i),
        .dp_i          (dp_i),
        .frame_valid_i (frame_valid_i),
        .frame_ready_o (frame_ready_o),
        .brightness_i  (brightness_i),
        .an_o          (an_o),
        .sseg_o        (sseg_o),
        .dp_o          (dp_o),
        .frame_start_o (frame_start_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: t counts cycles since reset release; slot, digit and PWM phase
    // all follow from it arithmetically.
    int            t = 0;
    logic [31:0]   m_active = '1;
    logic [31:0]   m_pend[$];
    logic [BW-1:0] m_latch = '0;
    bit            m_acc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic [3:0]    e_an;
        logic [6:0]    e_seg;
        logic          e_dp;
        logic          e_fs;
        bit            e_lit;
        int            slot, dig, pw;
        bit            boundary, acc, rst_now;
        logic [31:0]   data;
        logic [BW-1:0] bri;
        rst_now  = !rst_i;
        acc      = 0;
        boundary = 0;
        data     = {dp_i, frame_i};
        bri      = brightness_i;
        if (rst_now) begin
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fs = 1'b0;
        end else begin
            slot     = t % DC;
            dig      = (t / DC) % 4;
            pw       = t % (1 << BW);
            boundary = (t % (4 * DC)) == 0;
            e_lit    = (slot >= BC) && ((m_latch == '1) || (pw < int'(m_latch)));
            e_an     = e_lit ? ~(4'b0001 << dig) : 4'hF;
            e_seg    = e_lit ? m_active[7*dig +: 7] : 7'h7F;
            e_dp     = e_lit ? m_active[28+dig] : 1'b1;
            e_fs     = boundary;
            acc      = frame_valid_i && (m_pend.size() == 0);
        end
        @(posedge clk);
        #1;
        if (rst_now) begin
            t        = 0;
            m_active = '1;
            m_pend.delete();
            m_latch  = '0;
        end else begin
            if (boundary) begin
                m_latch = bri;
                if (m_pend.size() != 0) m_active = m_pend.pop_front();
            end
            if (acc) m_pend.push_back(data);
            t++;
        end
        m_acc = acc;
        check("an_o", 32'(an_o), 32'(e_an));
        check("sseg_o", 32'(sseg_o), 32'(e_seg));
        check("dp_o", 32'(dp_o), 32'(e_dp));
        check("frame_start_o", 32'(frame_start_o), 32'(e_fs));
        check("frame_ready_o", 32'(frame_ready_o), 32'(m_pend.size() == 0));
    endtask

    task automatic push(input logic [27:0] seg, input logic [3:0] dp);
        bit got = 0;
        frame_valid_i = 1'b1;
        frame_i       = seg;
        dp_i          = dp;
        for (int i = 0; i < 100; i++) begin
            step();
            if (m_acc) begin
                got = 1;
                break;
            end
        end
        frame_valid_i = 1'b0;
        n_assert++;
        assert (got) else begin
            n_fail++;
            $error("FAIL push: frame not accepted within 100 cycles");
        end
        check("push_ready_fall", 32'(frame_ready_o), 32'd0);
    endtask

    task automatic wait_fs();
        bit got = 0;
        for (int i = 0; i < 80; i++) begin
            step();
            if (frame_start_o === 1'b1) begin
                got = 1;
                break;
            end
        end
        n_assert++;
        assert (got) else begin
            n_fail++;
            $error("FAIL wait_fs: no frame_start_o within 80 cycles");
        end
    endtask

    initial begin
        int n;
        rst_i         = 1'b0;
        frame_valid_i = 1'b0;
        frame_i       = '0;
        dp_i          = '0;
        brightness_i  = 2'd3;

        // Reset and idle scanning of the blank buffer.
        repeat (3) step();
        check("rst_ready", 32'(frame_ready_o), 32'd1);
        rst_i = 1'b1;
        n = 0;
        repeat (64) begin
            step();
            if (frame_start_o === 1'b1) n++;
        end
        check("idle_fs_count", 32'(n), 32'd2);
        repeat (10) step();

        // Load a known frame and probe the digit0 and digit3 slots.
        push({7'h30, 7'h24, 7'h79, 7'h40}, 4'b1110);
        wait_fs();
        step();
        check("load_d0_blank", 32'(an_o), 32'hF);
        step();
        check("load_d0_an", 32'(an_o), 32'b1110);
        check("load_d0_seg", 32'(sseg_o), 32'h40);
        check("load_d0_dp", 32'(dp_o), 32'd0);
        repeat (5) step();
        check("load_d0_end_an", 32'(an_o), 32'b1110);
        repeat (19) step();
        check("load_d3_an", 32'(an_o), 32'b0111);
        check("load_d3_seg", 32'(sseg_o), 32'h30);
        check("load_d3_dp", 32'(dp_o), 32'd1);

        // Back-pressure: second frame is held until the boundary frees pending.
        push(28'($urandom), 4'($urandom));
        frame_valid_i = 1'b1;
        frame_i       = 28'($urandom);
        dp_i          = 4'($urandom);
        repeat (3) begin
            step();
            check("bp_ready_low", 32'(frame_ready_o), 32'd0);
        end
        push(frame_i, dp_i);
        repeat (2) wait_fs();

        // Accept landing exactly on a boundary stays pending for a frame.
        repeat (31) step();
        frame_valid_i = 1'b1;
        frame_i       = 28'($urandom);
        dp_i          = 4'($urandom);
        step();
        frame_valid_i = 1'b0;
        check("coll_pending", 32'(frame_ready_o), 32'd0);
        wait_fs();
        check("coll_promoted", 32'(frame_ready_o), 32'd1);

        // Brightness: dark frame, then latch 2 with a mid-frame change ignored.
        brightness_i = 2'd0;
        wait_fs();
        n = 0;
        repeat (32) begin
            step();
            if (an_o !== 4'hF) n++;
        end
        check("bright0_lit", 32'(n), 32'd0);
        brightness_i = 2'd2;
        wait_fs();
        n = 0;
        repeat (10) begin
            step();
            if (an_o !== 4'hF) n++;
        end
        brightness_i = 2'd3;
        repeat (22) begin
            step();
            if (an_o !== 4'hF) n++;
        end
        check("bright2_lit", 32'(n), 32'd8);

        // Reset during digit2 with a frame pending.
        wait_fs();
        repeat (16) step();
        push(28'($urandom), 4'($urandom));
        rst_i = 1'b0;
        step();
        check("midrst_an", 32'(an_o), 32'hF);
        check("midrst_ready", 32'(frame_ready_o), 32'd1);
        rst_i = 1'b1;
        n = 0;
        repeat (70) begin
            step();
            if (sseg_o !== 7'h7F) n++;
        end
        check("midrst_blank", 32'(n), 32'd0);

        // Randomized traffic, brightness and occasional resets.
        for (int i = 0; i < 400; i++) begin
            if (!frame_valid_i && $urandom_range(0, 5) == 0) begin
                frame_valid_i = 1'b1;
                frame_i       = 28'($urandom);
                dp_i          = 4'($urandom);
            end
            if ($urandom_range(0, 15) == 0) brightness_i = BW'($urandom);
            rst_i = ($urandom_range(0, 199) != 0);
            step();
            if (m_acc) frame_valid_i = 1'b0;
        end
        rst_i = 1'b1;
        frame_valid_i = 1'b0;
        repeat (40) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
